vga_scanout: RTL



---
 rtl/vga_pkg.sv | 64 ++++++
 rtl/vga_scanout_if.sv | 12 +
 rtl/vga_timing.sv | 73 +++++++
 rtl/vga_scanout.sv | 125 ++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 VGA timing, 160x120 framebuffer geometry and colours.
// Build macro SCANOUT_TESTPAT_EN enables the colour-bar helper users.
package vga_pkg;

    localparam int XRES       = 160;
    localparam int YRES       = 120;
    localparam int SCALE_LOG2 = 2;
    localparam int ADDR_W     = 15;
    localparam int CNT_W      = 10;

    localparam int H_VIS  = 640;
    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;
    localparam int V_VIS  = 480;
    localparam int V_FP   = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;

    localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VIS + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VIS + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    typedef logic [2:0] colour_t;

    localparam colour_t BLACK   = 3'b000;
    localparam colour_t BLUE    = 3'b001;
    localparam colour_t GREEN   = 3'b010;
    localparam colour_t CYAN    = 3'b011;
    localparam colour_t RED     = 3'b100;
    localparam colour_t MAGENTA = 3'b101;
    localparam colour_t YELLOW  = 3'b110;
    localparam colour_t WHITE   = 3'b111;

    typedef struct packed {
        logic hs;
        logic vs;
        logic vis;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0};

    // y*160 + x as two shifts and an add
    function automatic logic [ADDR_W-1:0] fb_addr(
        input logic [7:0] fx,
        input logic [7:0] fy
    );
        fb_addr = ({7'd0, fy} << 7) + ({7'd0, fy} << 5) + {7'd0, fx};
    endfunction

    // eight 20-pixel-wide bars across the 160-pixel width
    function automatic colour_t bar_colour(input logic [7:0] fx);
        colour_t c;
        c = BLACK;
        for (int i = 1; i < 8; i++) begin
            if (fx >= 8'(20 * i)) c = c + 3'd1;
        end
        return c;
    endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// vga_scanout_if: framebuffer read port between scanout (master) and RAM.
interface vga_scanout_if;
    import vga_pkg::*;

    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    colour_t           rd_data;

    modport master (output rd_addr, output rd_en, input rd_data);
    modport slave  (input rd_addr, input rd_en, output rd_data);

endinterface

// File: rtl/vga_timing.sv
// vga_timing: pixel enable, h/v counters, raw sync/visible and frame strobe.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VIS_P  = H_VIS,
    parameter int H_FP_P   = H_FP,
    parameter int H_SYNC_P = H_SYNC,
    parameter int H_BP_P   = H_BP,
    parameter int V_VIS_P  = V_VIS,
    parameter int V_FP_P   = V_FP,
    parameter int V_SYNC_P = V_SYNC,
    parameter int V_BP_P   = V_BP
) (
    input  logic             Clock,
    input  logic             Reset,
    output logic             pix_en,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             hs_raw,
    output logic             vs_raw,
    output logic             visible,
    output logic             frame_start
);

    localparam int HT  = H_VIS_P + H_FP_P + H_SYNC_P + H_BP_P;
    localparam int VT  = V_VIS_P + V_FP_P + V_SYNC_P + V_BP_P;
    localparam int HSS = H_VIS_P + H_FP_P;
    localparam int HSE = HSS + H_SYNC_P;
    localparam int VSS = V_VIS_P + V_FP_P;
    localparam int VSE = VSS + V_SYNC_P;

    logic             pix_en_q, pix_en_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;

    always_comb begin
        pix_en_d = ~pix_en_q;
        hcnt_d   = hcnt_q;
        vcnt_d   = vcnt_q;
        if (pix_en_q) begin
            if (hcnt_q == CNT_W'(HT - 1)) begin
                hcnt_d = '0;
                if (vcnt_q == CNT_W'(VT - 1)) vcnt_d = '0;
                else vcnt_d = vcnt_q + CNT_W'(1);
            end else begin
                hcnt_d = hcnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pix_en_q <= 1'b0;
            hcnt_q   <= '0;
            vcnt_q   <= '0;
        end else begin
            pix_en_q <= pix_en_d;
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
        end
    end

    assign pix_en  = pix_en_q;
    assign hcnt    = hcnt_q;
    assign vcnt    = vcnt_q;
    assign hs_raw  = !(hcnt_q >= CNT_W'(HSS) && hcnt_q < CNT_W'(HSE));
    assign vs_raw  = !(vcnt_q >= CNT_W'(VSS) && vcnt_q < CNT_W'(VSE));
    assign visible = (hcnt_q < CNT_W'(H_VIS_P)) && (vcnt_q < CNT_W'(V_VIS_P));

    assign frame_start = pix_en_q && (hcnt_q == '0)
                      && (vcnt_q == CNT_W'(V_VIS_P));

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: framebuffer read, 4x upscale and VGA pin drive.
// Build macro SCANOUT_TESTPAT_EN adds test_en and the colour-bar source.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_VIS_P  = H_VIS,
    parameter int H_FP_P   = H_FP,
    parameter int H_SYNC_P = H_SYNC,
    parameter int H_BP_P   = H_BP,
    parameter int V_VIS_P  = V_VIS,
    parameter int V_FP_P   = V_FP,
    parameter int V_SYNC_P = V_SYNC,
    parameter int V_BP_P   = V_BP
) (
    input  logic                 Clock,
    input  logic                 Reset,
`ifdef SCANOUT_TESTPAT_EN
    input  logic                 test_en,
`endif
    vga_scanout_if.master        fb,
    output logic                 frame_start,
    output logic [7:0]           VGA_R,
    output logic [7:0]           VGA_G,
    output logic [7:0]           VGA_B,
    output logic                 VGA_HS,
    output logic                 VGA_VS,
    output logic                 VGA_BLANK_N,
    output logic                 VGA_SYNC_N,
    output logic                 VGA_CLK
);

    logic             pix_en, hs_raw, vs_raw, visible;
    logic [CNT_W-1:0] hcnt, vcnt;
    logic [7:0]       fx, fy;

    vga_timing #(
        .H_VIS_P (H_VIS_P),  .H_FP_P (H_FP_P),
        .H_SYNC_P(H_SYNC_P), .H_BP_P (H_BP_P),
        .V_VIS_P (V_VIS_P),  .V_FP_P (V_FP_P),
        .V_SYNC_P(V_SYNC_P), .V_BP_P (V_BP_P)
    ) u_timing (
        .Clock      (Clock),
        .Reset      (Reset),
        .pix_en     (pix_en),
        .hcnt       (hcnt),
        .vcnt       (vcnt),
        .hs_raw     (hs_raw),
        .vs_raw     (vs_raw),
        .visible    (visible),
        .frame_start(frame_start)
    );

    assign fx = 8'(hcnt >> SCALE_LOG2);
    assign fy = 8'(vcnt >> SCALE_LOG2);

    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_en_q, rd_en_d;
    sync_t             sync1_q, sync1_d;
    sync_t             sync2_q, sync2_d;
    colour_t           colour_q, colour_d;
`ifdef SCANOUT_TESTPAT_EN
    colour_t           tp_q, tp_d;
`endif

    // stage 0 registers address and syncs; stage 1 captures RAM data
    always_comb begin
        rd_addr_d = rd_addr_q;
        rd_en_d   = rd_en_q;
        sync1_d   = sync1_q;
        sync2_d   = sync2_q;
        colour_d  = colour_q;
`ifdef SCANOUT_TESTPAT_EN
        tp_d      = tp_q;
`endif
        if (pix_en) begin
            rd_addr_d = fb_addr(fx, fy);
            rd_en_d   = visible;
            sync1_d   = '{hs: hs_raw, vs: vs_raw, vis: visible};
            sync2_d   = sync1_q;
            colour_d  = rd_en_q ? fb.rd_data : BLACK;
`ifdef SCANOUT_TESTPAT_EN
            rd_en_d   = visible && !test_en;
            tp_d      = (visible && test_en) ? bar_colour(fx) : BLACK;
            if (!rd_en_q) colour_d = tp_q;
`endif
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rd_addr_q <= '0;
            rd_en_q   <= 1'b0;
            sync1_q   <= SYNC_IDLE;
            sync2_q   <= SYNC_IDLE;
            colour_q  <= BLACK;
`ifdef SCANOUT_TESTPAT_EN
            tp_q      <= BLACK;
`endif
        end else begin
            rd_addr_q <= rd_addr_d;
            rd_en_q   <= rd_en_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            colour_q  <= colour_d;
`ifdef SCANOUT_TESTPAT_EN
            tp_q      <= tp_d;
`endif
        end
    end

    colour_t pix;
    assign pix = sync2_q.vis ? colour_q : BLACK;

    assign fb.rd_addr  = rd_addr_q;
    assign fb.rd_en    = rd_en_q;
    assign VGA_R       = {8{pix[2]}};
    assign VGA_G       = {8{pix[1]}};
    assign VGA_B       = {8{pix[0]}};
    assign VGA_HS      = sync2_q.hs;
    assign VGA_VS      = sync2_q.vs;
    assign VGA_BLANK_N = sync2_q.vis;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = pix_en;

endmodule
